mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter for a single 8-bit memory
//               port. Optional ack timeout enabled by `define MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_read,
    input  logic       m0_write,
    input  logic [7:0] m0_address,
    input  logic [7:0] m0_dout,
    output logic [7:0] m0_din,
    output logic       m0_ready,
    input  logic       m1_read,
    input  logic       m1_write,
    input  logic [7:0] m1_address,
    input  logic [7:0] m1_dout,
    output logic [7:0] m1_din,
    output logic       m1_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_mem_read, w_mem_read_nxt;
    logic       r_mem_write, w_mem_write_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic [7:0] r_m0_din, w_m0_din_nxt;
    logic [7:0] r_m1_din, w_m1_din_nxt;
    logic       r_m0_ready, w_m0_ready_nxt;
    logic       r_m1_ready, w_m1_ready_nxt;
    logic       r_last, w_last_nxt;   // 1: m1 served last, 0: m0 served last

    logic       w_req0, w_req1;
    logic       w_grant0, w_grant1;
    logic       w_timeout;
    logic       w_done, w_fault;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_bus_err;

    assign w_timeout = (r_state != IDLE) && (r_cnt == (TIMEOUT_CYCLES - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 8'h00;
            r_bus_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == IDLE) ? 8'h00 : r_cnt + 8'd1;
            if (w_fault)
                r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    assign w_done  = mem_ack | w_timeout;
    assign w_fault = ~mem_ack & w_timeout;

    // A ready pulse marks the mandatory idle cycle: the served requester's
    // request may still be high and must not be taken as a new one.
    assign w_grant0 = (r_state == IDLE) && !r_m0_ready && !r_m1_ready &&
                      w_req0 && (!w_req1 || r_last);
    assign w_grant1 = (r_state == IDLE) && !r_m0_ready && !r_m1_ready &&
                      w_req1 && !w_grant0;

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_m0_din_nxt    = r_m0_din;
        w_m1_din_nxt    = r_m1_din;
        w_m0_ready_nxt  = 1'b0;
        w_m1_ready_nxt  = 1'b0;
        w_last_nxt      = r_last;

        case (r_state)
            IDLE: begin
                if (w_grant0) begin
                    w_state_nxt     = BUSY0;
                    w_mem_write_nxt = m0_write;
                    w_mem_read_nxt  = ~m0_write;
                    w_addr_nxt      = m0_address;
                    w_wdata_nxt     = m0_dout;
                end else if (w_grant1) begin
                    w_state_nxt     = BUSY1;
                    w_mem_write_nxt = m1_write;
                    w_mem_read_nxt  = ~m1_write;
                    w_addr_nxt      = m1_address;
                    w_wdata_nxt     = m1_dout;
                end
            end
            BUSY0: begin
                if (w_done) begin
                    w_state_nxt     = IDLE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_m0_ready_nxt  = 1'b1;
                    w_last_nxt      = 1'b0;
                    if (w_fault)
                        w_m0_din_nxt = 8'hFF;
                    else if (r_mem_read)
                        w_m0_din_nxt = mem_rdata;
                end
            end
            BUSY1: begin
                if (w_done) begin
                    w_state_nxt     = IDLE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_m1_ready_nxt  = 1'b1;
                    w_last_nxt      = 1'b1;
                    if (w_fault)
                        w_m1_din_nxt = 8'hFF;
                    else if (r_mem_read)
                        w_m1_din_nxt = mem_rdata;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_m0_din    <= 8'h00;
            r_m1_din    <= 8'h00;
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_m0_din    <= w_m0_din_nxt;
            r_m1_din    <= w_m1_din_nxt;
            r_m0_ready  <= w_m0_ready_nxt;
            r_m1_ready  <= w_m1_ready_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign m0_din      = r_m0_din;
    assign m1_din      = r_m1_din;
    assign m0_ready    = r_m0_ready;
    assign m1_ready    = r_m1_ready;

endmodule
`default_nettype wire
